// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds renamed arithmetic ops until both operands are
// present (directly or via CDB snoop) and dispatches the lowest-index ready one.
module alu_reservation_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_WIDTH   = 3,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,

  input  logic                          issue_valid,
  input  logic                          issue_arith,
  input  logic [2:0]                    issue_funct3,
  input  logic                          issue_funct7,
  input  logic                          issue_src1_rdy,
  input  logic [DATA_WIDTH-1:0]         issue_src1_data,
  input  logic [TAG_WIDTH-1:0]          issue_src1_tag,
  input  logic                          issue_src2_rdy,
  input  logic [DATA_WIDTH-1:0]         issue_src2_data,
  input  logic [TAG_WIDTH-1:0]          issue_src2_tag,
  input  logic [TAG_WIDTH-1:0]          issue_dest_tag,
  output logic                          rs_full,
  output logic [$clog2(NUM_ENTRIES):0]  rs_count,

  input  logic                          cdb_valid,
  input  logic [TAG_WIDTH-1:0]          cdb_tag,
  input  logic [DATA_WIDTH-1:0]         cdb_data,

  output logic                          alu_valid,
  input  logic                          alu_ready,
  output logic                          alu_arith,
  output logic [2:0]                    alu_funct3,
  output logic                          alu_funct7,
  output logic [DATA_WIDTH-1:0]         alu_src1_data,
  output logic [DATA_WIDTH-1:0]         alu_src2_data,
  output logic [TAG_WIDTH-1:0]          alu_tag
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

  logic [NUM_ENTRIES-1:0]                 busy_q;
  logic [NUM_ENTRIES-1:0]                 arith_q;
  logic [NUM_ENTRIES-1:0][2:0]            funct3_q;
  logic [NUM_ENTRIES-1:0]                 funct7_q;
  logic [NUM_ENTRIES-1:0][TAG_WIDTH-1:0]  dest_tag_q;
  logic [NUM_ENTRIES-1:0]                 src1_rdy_q;
  logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] src1_data_q;
  logic [NUM_ENTRIES-1:0][TAG_WIDTH-1:0]  src1_tag_q;
  logic [NUM_ENTRIES-1:0]                 src2_rdy_q;
  logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] src2_data_q;
  logic [NUM_ENTRIES-1:0][TAG_WIDTH-1:0]  src2_tag_q;

  logic [CNT_W-1:0]       count_q;
  logic                   lock_q;
  logic [IDX_W-1:0]       lock_idx_q;

  logic [NUM_ENTRIES-1:0] ready_vec;
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       low_idx;
  logic [IDX_W-1:0]       sel_idx;
  logic                   issue_fire;
  logic                   dispatch_fire;
  logic                   iss_src1_rdy;
  logic                   iss_src2_rdy;
  logic [DATA_WIDTH-1:0]  iss_src1_data;
  logic [DATA_WIDTH-1:0]  iss_src2_data;

  assign ready_vec = busy_q & src1_rdy_q & src2_rdy_q;
  assign alu_valid = |ready_vec;
  assign rs_count  = count_q;
  assign rs_full   = (count_q == CNT_W'(NUM_ENTRIES));

  // Descending scan so the last hit wins: lowest free slot and lowest ready entry.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    low_idx    = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready_vec[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // A stalled dispatch keeps its entry even if a lower-index one becomes ready.
  assign sel_idx = lock_q ? lock_idx_q : low_idx;

  assign issue_fire    = issue_valid && !rs_full && free_found && !flush;
  assign dispatch_fire = alu_valid && alu_ready && !flush;

  // Same-cycle CDB bypass so a broadcast coinciding with issue is not lost.
  always_comb begin
    iss_src1_rdy  = issue_src1_rdy;
    iss_src1_data = issue_src1_data;
    iss_src2_rdy  = issue_src2_rdy;
    iss_src2_data = issue_src2_data;
    if (!issue_src1_rdy && cdb_valid && (cdb_tag == issue_src1_tag)) begin
      iss_src1_rdy  = 1'b1;
      iss_src1_data = cdb_data;
    end
    if (!issue_src2_rdy && cdb_valid && (cdb_tag == issue_src2_tag)) begin
      iss_src2_rdy  = 1'b1;
      iss_src2_data = cdb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      arith_q     <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      dest_tag_q  <= '0;
      src1_rdy_q  <= '0;
      src1_data_q <= '0;
      src1_tag_q  <= '0;
      src2_rdy_q  <= '0;
      src2_data_q <= '0;
      src2_tag_q  <= '0;
      count_q     <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
    end else if (flush) begin
      busy_q     <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (issue_fire && (free_idx == IDX_W'(i))) begin
          busy_q[i]      <= 1'b1;
          arith_q[i]     <= issue_arith;
          funct3_q[i]    <= issue_funct3;
          funct7_q[i]    <= issue_funct7;
          dest_tag_q[i]  <= issue_dest_tag;
          src1_rdy_q[i]  <= iss_src1_rdy;
          src1_data_q[i] <= iss_src1_data;
          src1_tag_q[i]  <= issue_src1_tag;
          src2_rdy_q[i]  <= iss_src2_rdy;
          src2_data_q[i] <= iss_src2_data;
          src2_tag_q[i]  <= issue_src2_tag;
        end else begin
          if (dispatch_fire && (sel_idx == IDX_W'(i))) begin
            busy_q[i] <= 1'b0;
          end
          if (busy_q[i] && cdb_valid) begin
            if (!src1_rdy_q[i] && (src1_tag_q[i] == cdb_tag)) begin
              src1_rdy_q[i]  <= 1'b1;
              src1_data_q[i] <= cdb_data;
            end
            if (!src2_rdy_q[i] && (src2_tag_q[i] == cdb_tag)) begin
              src2_rdy_q[i]  <= 1'b1;
              src2_data_q[i] <= cdb_data;
            end
          end
        end
      end
      count_q    <= count_q + {{(CNT_W-1){1'b0}}, issue_fire}
                            - {{(CNT_W-1){1'b0}}, dispatch_fire};
      lock_q     <= alu_valid && !alu_ready;
      lock_idx_q <= sel_idx;
    end
  end

  always_comb begin
    alu_arith     = 1'b0;
    alu_funct3    = '0;
    alu_funct7    = 1'b0;
    alu_src1_data = '0;
    alu_src2_data = '0;
    alu_tag       = '0;
    if (alu_valid) begin
      alu_arith     = arith_q[sel_idx];
      alu_funct3    = funct3_q[sel_idx];
      alu_funct7    = funct7_q[sel_idx];
      alu_src1_data = src1_data_q[sel_idx];
      alu_src2_data = src2_data_q[sel_idx];
      alu_tag       = dest_tag_q[sel_idx];
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed, table-driven bench for alu_reservation_station: each record gives the
// outputs expected in a cycle and the inputs driven into that cycle's edge.
module tb_alu_reservation_station;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        issue_valid, issue_arith, issue_funct7;
  logic [2:0]  issue_funct3;
  logic        issue_src1_rdy, issue_src2_rdy;
  logic [31:0] issue_src1_data, issue_src2_data;
  logic [2:0]  issue_src1_tag, issue_src2_tag, issue_dest_tag;
  logic        rs_full;
  logic [2:0]  rs_count;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        alu_valid, alu_ready, alu_arith, alu_funct7;
  logic [2:0]  alu_funct3, alu_tag;
  logic [31:0] alu_src1_data, alu_src2_data;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_reservation_station #(.NUM_ENTRIES(4), .TAG_WIDTH(3), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_arith(issue_arith),
    .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
    .issue_src1_rdy(issue_src1_rdy), .issue_src1_data(issue_src1_data),
    .issue_src1_tag(issue_src1_tag),
    .issue_src2_rdy(issue_src2_rdy), .issue_src2_data(issue_src2_data),
    .issue_src2_tag(issue_src2_tag),
    .issue_dest_tag(issue_dest_tag), .rs_full(rs_full), .rs_count(rs_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_arith(alu_arith),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_src1_data(alu_src1_data), .alu_src2_data(alu_src2_data),
    .alu_tag(alu_tag)
  );

  typedef struct {
    string       name;
    logic        rst, fl, iv, arith, f7, s1r, s2r, cv, ardy;
    logic [2:0]  f3, s1t, s2t, dt, ct;
    logic [31:0] s1d, s2d, cd;
    logic        ev, earith, ef7, efull;
    logic [2:0]  ef3, etag, ecnt;
    logic [31:0] es1, es2;
  } vec_t;

  function automatic vec_t mkVec(string n, bit ardy, bit ev, logic [2:0] etag,
                                 logic [31:0] es1, logic [31:0] es2,
                                 logic [2:0] ecnt, bit efull);
    vec_t v;
    v.name = n; v.rst = 0; v.fl = 0; v.iv = 0; v.arith = 0; v.f7 = 0;
    v.s1r = 0; v.s2r = 0; v.cv = 0; v.ardy = ardy;
    v.f3 = 0; v.s1t = 0; v.s2t = 0; v.dt = 0; v.ct = 0;
    v.s1d = 0; v.s2d = 0; v.cd = 0;
    v.ev = ev; v.earith = 0; v.ef7 = 0; v.efull = efull; v.ef3 = 0;
    v.etag = etag; v.ecnt = ecnt; v.es1 = es1; v.es2 = es2;
    return v;
  endfunction

  function automatic vec_t withIssue(vec_t v, bit arith, logic [2:0] f3, bit f7,
                                     bit s1r, logic [31:0] s1d, logic [2:0] s1t,
                                     bit s2r, logic [31:0] s2d, logic [2:0] s2t,
                                     logic [2:0] dt);
    v.iv = 1; v.arith = arith; v.f3 = f3; v.f7 = f7;
    v.s1r = s1r; v.s1d = s1d; v.s1t = s1t;
    v.s2r = s2r; v.s2d = s2d; v.s2t = s2t; v.dt = dt;
    return v;
  endfunction

  function automatic vec_t withCdb(vec_t v, logic [2:0] t, logic [31:0] d);
    v.cv = 1; v.ct = t; v.cd = d;
    return v;
  endfunction

  function automatic vec_t expectOp(vec_t v, bit a, logic [2:0] f3, bit f7);
    v.earith = a; v.ef3 = f3; v.ef7 = f7;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    if (v.iv && rs_full && !v.rst && !v.fl)
      $display("[TB] protocol error: issue of tag %0d while rs_full, dropped", v.dt);
    rst = v.rst; flush = v.fl;
    issue_valid = v.iv; issue_arith = v.arith; issue_funct3 = v.f3; issue_funct7 = v.f7;
    issue_src1_rdy = v.s1r; issue_src1_data = v.s1d; issue_src1_tag = v.s1t;
    issue_src2_rdy = v.s2r; issue_src2_data = v.s2d; issue_src2_tag = v.s2t;
    issue_dest_tag = v.dt;
    cdb_valid = v.cv; cdb_tag = v.ct; cdb_data = v.cd;
    alu_ready = v.ardy;
  endtask

  task automatic cmp(input string vname, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", vname, field, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    cmp(v.name, "alu_valid", 32'(alu_valid),  32'(v.ev));
    cmp(v.name, "alu_tag",   32'(alu_tag),    32'(v.etag));
    cmp(v.name, "alu_src1",  alu_src1_data,   v.es1);
    cmp(v.name, "alu_src2",  alu_src2_data,   v.es2);
    cmp(v.name, "alu_arith", 32'(alu_arith),  32'(v.earith));
    cmp(v.name, "alu_f3",    32'(alu_funct3), 32'(v.ef3));
    cmp(v.name, "alu_f7",    32'(alu_funct7), 32'(v.ef7));
    cmp(v.name, "rs_count",  32'(rs_count),   32'(v.ecnt));
    cmp(v.name, "rs_full",   32'(rs_full),    32'(v.efull));
  endtask

  task automatic runVec(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(v);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    v = mkVec("init", 0, 0, 0, 0, 0, 0, 0);
    v.rst = 1;
    applyStimulus(v);
    repeat (2) @(negedge clk);

    // basic issue + dispatch
    vecs.push_back(withIssue(mkVec("reset_state", 0, 0, 0, 0, 0, 0, 0),
                             1, 3'd0, 0, 1, 32'd5, 0, 1, 32'd7, 0, 3'd2));
    vecs.push_back(expectOp(mkVec("add_ready", 1, 1, 3'd2, 32'd5, 32'd7, 3'd1, 0), 1, 3'd0, 0));
    // wake-up via CDB
    vecs.push_back(withIssue(mkVec("add_gone", 1, 0, 0, 0, 0, 3'd0, 0),
                             1, 3'd7, 0, 0, 32'd0, 3'd3, 1, 32'd9, 0, 3'd4));
    vecs.push_back(withCdb(mkVec("wait_src1", 0, 0, 0, 0, 0, 3'd1, 0), 3'd3, 32'h10));
    vecs.push_back(expectOp(mkVec("woken", 1, 1, 3'd4, 32'h10, 32'd9, 3'd1, 0), 1, 3'd7, 0));
    // bypass on issue
    vecs.push_back(withCdb(withIssue(mkVec("woken_gone", 0, 0, 0, 0, 0, 3'd0, 0),
                                     1, 3'd0, 1, 1, 32'd3, 0, 0, 32'd0, 3'd5, 3'd5),
                           3'd5, 32'hAA));
    vecs.push_back(expectOp(mkVec("bypass", 1, 1, 3'd5, 32'd3, 32'hAA, 3'd1, 0), 1, 3'd0, 1));
    // fill + backpressure
    vecs.push_back(withIssue(mkVec("fill0", 0, 0, 0, 0, 0, 3'd0, 0),
                             0, 0, 0, 1, 32'h100, 0, 1, 32'h200, 0, 3'd0));
    vecs.push_back(withIssue(mkVec("fill1", 0, 1, 3'd0, 32'h100, 32'h200, 3'd1, 0),
                             0, 0, 0, 1, 32'h101, 0, 1, 32'h201, 0, 3'd1));
    vecs.push_back(withIssue(mkVec("fill2", 0, 1, 3'd0, 32'h100, 32'h200, 3'd2, 0),
                             0, 0, 0, 1, 32'h102, 0, 1, 32'h202, 0, 3'd2));
    vecs.push_back(withIssue(mkVec("fill3", 0, 1, 3'd0, 32'h100, 32'h200, 3'd3, 0),
                             0, 0, 0, 1, 32'h103, 0, 1, 32'h203, 0, 3'd3));
    vecs.push_back(withIssue(mkVec("full_drop", 0, 1, 3'd0, 32'h100, 32'h200, 3'd4, 1),
                             0, 0, 0, 1, 32'h777, 0, 1, 32'h777, 0, 3'd7));
    vecs.push_back(mkVec("full_hold", 1, 1, 3'd0, 32'h100, 32'h200, 3'd4, 1));
    vecs.push_back(mkVec("drain1", 1, 1, 3'd1, 32'h101, 32'h201, 3'd3, 0));
    vecs.push_back(mkVec("drain2", 1, 1, 3'd2, 32'h102, 32'h202, 3'd2, 0));
    vecs.push_back(mkVec("drain3", 1, 1, 3'd3, 32'h103, 32'h203, 3'd1, 0));
    // ordering under a stalled dispatch
    vecs.push_back(withIssue(mkVec("drained", 0, 0, 0, 0, 0, 3'd0, 0),
                             0, 0, 0, 0, 32'd0, 3'd6, 1, 32'h0E, 0, 3'd0));
    vecs.push_back(withIssue(mkVec("ord_e0", 0, 0, 0, 0, 0, 3'd1, 0),
                             0, 0, 0, 1, 32'h11, 0, 0, 32'd0, 3'd1, 3'd1));
    vecs.push_back(withIssue(mkVec("ord_e1", 0, 0, 0, 0, 0, 3'd2, 0),
                             1, 3'd5, 1, 1, 32'h22, 0, 1, 32'h33, 0, 3'd2));
    vecs.push_back(withCdb(expectOp(mkVec("ord_e2", 0, 1, 3'd2, 32'h22, 32'h33, 3'd3, 0),
                                    1, 3'd5, 1), 3'd1, 32'h55));
    vecs.push_back(expectOp(mkVec("ord_lock", 0, 1, 3'd2, 32'h22, 32'h33, 3'd3, 0), 1, 3'd5, 1));
    vecs.push_back(expectOp(mkVec("ord_lock2", 1, 1, 3'd2, 32'h22, 32'h33, 3'd3, 0), 1, 3'd5, 1));
    vecs.push_back(mkVec("ord_e1_go", 1, 1, 3'd1, 32'h11, 32'h55, 3'd2, 0));
    // flush with three busy entries and a same-cycle issue
    vecs.push_back(withIssue(mkVec("ord_done", 1, 0, 0, 0, 0, 3'd1, 0),
                             0, 0, 0, 0, 32'd0, 3'd6, 1, 32'h3E, 0, 3'd3));
    vecs.push_back(withIssue(mkVec("pre_fl1", 0, 0, 0, 0, 0, 3'd2, 0),
                             0, 0, 0, 1, 32'h44, 0, 1, 32'h45, 0, 3'd4));
    v = withIssue(mkVec("pre_fl2", 1, 1, 3'd4, 32'h44, 32'h45, 3'd3, 0),
                  0, 0, 0, 1, 32'h50, 0, 1, 32'h51, 0, 3'd5);
    v.fl = 1;
    vecs.push_back(v);
    vecs.push_back(withCdb(mkVec("flushed", 1, 0, 0, 0, 0, 3'd0, 0), 3'd6, 32'h66));
    vecs.push_back(mkVec("flush_cdb", 1, 0, 0, 0, 0, 3'd0, 0));

    for (int i = 0; i < vecs.size(); i++) runVec(vecs[i]);

    // Hand sequence: issue, CDB capture and dispatch in one cycle, then reset priority.
    runVec(withIssue(mkVec("sim_i0", 0, 0, 0, 0, 0, 3'd0, 0),
                     0, 0, 0, 1, 32'hA1, 0, 1, 32'hA2, 0, 3'd1));
    runVec(withIssue(mkVec("sim_i1", 0, 1, 3'd1, 32'hA1, 32'hA2, 3'd1, 0),
                     0, 0, 0, 0, 32'd0, 3'd7, 1, 32'hB2, 0, 3'd2));
    runVec(withCdb(withIssue(mkVec("sim_all", 1, 1, 3'd1, 32'hA1, 32'hA2, 3'd2, 0),
                             0, 0, 0, 1, 32'hC1, 0, 1, 32'hC2, 0, 3'd3),
                   3'd7, 32'hB1));
    runVec(mkVec("sim_e1", 1, 1, 3'd2, 32'hB1, 32'hB2, 3'd2, 0));
    v = withIssue(mkVec("sim_e2", 1, 1, 3'd3, 32'hC1, 32'hC2, 3'd1, 0),
                  0, 0, 0, 1, 32'hD1, 0, 1, 32'hD2, 0, 3'd6);
    v.rst = 1;
    runVec(v);
    runVec(mkVec("after_rst", 0, 0, 0, 0, 0, 3'd0, 0));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Reservation station that sits in front of the ALU in the Tomasulo out-of-order core.
- Accepts renamed arithmetic instructions from the issue/decode stage.
- Holds each instruction until both source operands are available, capturing missing operands by snooping common data bus (CDB) broadcasts for matching tags.
- Dispatches one ready instruction per cycle to the ALU as an ALU operation word (op, src1_data, src2_data, funct3, funct7, tag).

Parameters:
NUM_ENTRIES, 4, number of station entries (2..8)
TAG_WIDTH, 3, width of rename/ROB tags
DATA_WIDTH, 32, operand width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all entries (branch mispredict)
issue_valid  in  1  issue request this cycle
issue_arith  in  1  1 = ARITH op (funct3/funct7 meaningful); 0 = plain add
issue_funct3  in  3  funct3 field
issue_funct7  in  1  funct7 bit 5 (sub/sra select)
issue_src1_rdy  in  1  src1 value already present
issue_src1_data  in  DATA_WIDTH  src1 value (valid when rdy)
issue_src1_tag  in  TAG_WIDTH  src1 producer tag (used when !rdy)
issue_src2_rdy / issue_src2_data / issue_src2_tag  in  1 / DATA_WIDTH / TAG_WIDTH  same for src2
issue_dest_tag  in  TAG_WIDTH  destination tag
rs_full  out  1  no free entry
rs_count  out  $clog2(NUM_ENTRIES)+1  occupied entries
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_WIDTH  broadcast tag
cdb_data  in  DATA_WIDTH  broadcast value
alu_valid  out  1  dispatch word valid
alu_ready  in  1  ALU accepts word this cycle
alu_arith  out  1  op of dispatched entry
alu_funct3  out  3  funct3 of dispatched entry
alu_funct7  out  1  funct7 of dispatched entry
alu_src1_data / alu_src2_data  out  DATA_WIDTH  operands of dispatched entry
alu_tag  out  TAG_WIDTH  destination tag of dispatched entry

Behaviour:
- Each entry holds: busy, arith, funct3, funct7, dest_tag, and per source {rdy, data, tag}. An entry is ready when busy and both rdy bits are set.
- Reset (rst=1):
  - All busy and rdy bits cleared.
  - rs_full=0, rs_count=0, alu_valid=0.
  - alu_* data outputs are 0.
  - rst has priority over every other input.
- Flush (flush=1, rst=0):
  - All busy bits cleared at the edge; issue and dispatch in that cycle are discarded.
  - Outputs match reset in the following cycle.
- Issue:
  - On issue_valid && !rs_full, write the lowest-index non-busy entry at the edge and set busy.
  - issue_valid while rs_full: request dropped, no state change; the bench flags it as a protocol error.
  - rs_full and rs_count reflect registered occupancy only. A same-cycle dispatch does not free a slot for a same-cycle issue.
- CDB wake-up:
  - Every cycle with cdb_valid, each busy entry whose source has rdy=0 and tag==cdb_tag captures cdb_data and sets rdy.
  - All matching sources in all entries update simultaneously.
- Same-cycle bypass on issue: if an issued source has rdy=0 and its tag equals cdb_tag while cdb_valid, the entry is written with rdy=1 and data=cdb_data. Without this the wake-up is lost.
- Dispatch selection and outputs:
  - alu_valid is combinational from registered state: 1 iff any entry is ready.
  - The selected entry is the lowest-index ready entry.
  - alu_* outputs show that entry's fields; outputs are 0 when alu_valid=0.
- Dispatch handshake:
  - On alu_valid && alu_ready, the selected entry's busy bit clears at the edge.
  - If alu_ready=0, the selected entry and alu_* outputs hold stable. A newly ready lower-index entry may preempt selection only after the handshake completes; selection is locked while alu_valid && !alu_ready.
- Latency:
  - An issued entry with both sources rdy (or bypassed) asserts alu_valid in the cycle after issue.
  - An entry woken by CDB in cycle N is dispatchable in cycle N+1.
- Count rules:
  - rs_count next = count + issue_accepted − dispatch_fired, and never exceeds NUM_ENTRIES.
  - rs_full = (rs_count == NUM_ENTRIES).
- Simultaneous events:
  - Issue, CDB capture and dispatch may all occur in one cycle, each on different entries.
  - The dispatched entry's CDB match is irrelevant, because its sources are already rdy.

Test Plan:
- Reset, then issue arith add (src1=5, src2=7, both rdy, dest_tag=2) -> next cycle alu_valid=1, alu_src1=5, alu_src2=7, alu_tag=2; alu_ready=1 -> following cycle alu_valid=0, rs_count=0.
- Wake-up:
  - Issue with src1 rdy=0 tag=3, src2=9 rdy -> alu_valid stays 0.
  - cdb_valid tag=3 data=0x10 in cycle N -> alu_valid=1 in N+1 with src1=0x10.
- Bypass: issue src2 rdy=0 tag=5 in the same cycle as cdb_valid tag=5 data=0xAA -> next cycle alu_valid=1, alu_src2=0xAA.
- Fill and backpressure:
  - Issue 4 ready ops (tags 0..3) with alu_ready=0 -> rs_full=1, rs_count=4; a fifth issue is dropped and alu_tag holds 0 stably.
  - Raise alu_ready -> tags dispatch 0,1,2,3 on consecutive cycles.
- Ordering: entry 2 ready, entries 0 and 1 waiting; wake entry 1 via CDB while entry 2 is stalled by alu_ready=0 -> entry 2 dispatches first, then entry 1.
- Flush with 3 busy entries and issue_valid=1 in the same cycle -> next cycle rs_count=0, alu_valid=0, rs_full=0; a later CDB broadcast produces no dispatch.
